// File: rtl/controle_jogo_sequencia_pkg.sv
// Shared definitions for the sequence-memory game control unit:
// state encodings, default timer lengths and a timer width helper.
package controle_jogo_sequencia_pkg;

    typedef enum logic [4:0] {
        E_INICIAL        = 5'h00,
        E_PREPARA        = 5'h01,
        E_MOSTRA         = 5'h02,
        E_APAGA          = 5'h03,
        E_ESPERA         = 5'h04,
        E_REGISTRA       = 5'h05,
        E_COMPARA        = 5'h06,
        E_PROXIMA        = 5'h07,
        E_ESPERA_NOVA    = 5'h08,
        E_REGISTRA_NOVA  = 5'h09,
        E_ESCREVE        = 5'h0A,
        E_PROXIMA_RODADA = 5'h0B,
        E_FIM_GANHOU     = 5'h0C,
        E_FIM_PERDEU     = 5'h0D,
        E_FIM_TIMEOUT    = 5'h0E
    } estado_t;

    localparam int MOSTRA_CICLOS_DEF  = 1000;
    localparam int TIMEOUT_CICLOS_DEF = 3000;

    // Counter width for a limit; never narrower than one bit.
    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controle_jogo_sequencia_contador_limite.sv
// Saturating cycle counter: fim is high while the count sits at LIMITE-1.
// zera clears synchronously and has priority over conta.
module contador_limite
    import controle_jogo_sequencia_pkg::*;
#(
    parameter int LIMITE = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = largura(LIMITE);
    localparam logic [W-1:0] MAXIMO = W'(LIMITE - 1);

    logic [W-1:0] r_contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (zera) begin
            r_contagem <= '0;
        end else if (conta && (r_contagem != MAXIMO)) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign fim = (r_contagem == MAXIMO);

endmodule

// File: rtl/controle_jogo_sequencia.sv
// Control unit for the sequence-memory game: Moore FSM plus display and
// timeout timers, driving every datapath enable from the current state.
module controle_jogo_sequencia
    import controle_jogo_sequencia_pkg::*;
#(
    parameter int MOSTRA_CICLOS  = MOSTRA_CICLOS_DEF,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
    // The datapath compares its round counter against this value to build fimRodadas.
    parameter int ULTIMA_RODADA  = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       fimRodadas,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       escreveM,
    output logic       ativa_leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [4:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;

    logic w_conta_mostra;
    logic w_conta_timeout;
    logic w_fim_mostra;
    logic w_fim_timeout;

    // Each timer is held clear outside the state(s) in which it counts.
    assign w_conta_mostra  = (r_estado == E_MOSTRA);
    assign w_conta_timeout = (r_estado == E_ESPERA) || (r_estado == E_ESPERA_NOVA);

    contador_limite #(.LIMITE(MOSTRA_CICLOS)) u_timer_mostra (
        .clock (clock),
        .reset (reset),
        .zera  (~w_conta_mostra),
        .conta (w_conta_mostra),
        .fim   (w_fim_mostra)
    );

    contador_limite #(.LIMITE(TIMEOUT_CICLOS)) u_timer_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (~w_conta_timeout),
        .conta (w_conta_timeout),
        .fim   (w_fim_timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= E_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo  = r_estado;
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraR      = 1'b0;
        contaR     = 1'b0;
        registraR  = 1'b0;
        escreveM   = 1'b0;
        ativa_leds = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;

        case (r_estado)
            E_INICIAL: begin
                if (iniciar) w_proximo = E_PREPARA;
            end
            E_PREPARA: begin
                zeraE     = 1'b1;
                zeraR     = 1'b1;
                w_proximo = E_MOSTRA;
            end
            E_MOSTRA: begin
                ativa_leds = 1'b1;
                if (w_fim_mostra) w_proximo = E_APAGA;
            end
            E_APAGA: begin
                zeraE     = 1'b1;
                w_proximo = E_ESPERA;
            end
            // A play arriving in the very cycle the timer expires still counts.
            E_ESPERA: begin
                if (jogada_feita)       w_proximo = E_REGISTRA;
                else if (w_fim_timeout) w_proximo = E_FIM_TIMEOUT;
            end
            E_REGISTRA: begin
                registraR = 1'b1;
                w_proximo = E_COMPARA;
            end
            E_COMPARA: begin
                if (!igual)                    w_proximo = E_FIM_PERDEU;
                else if (!enderecoIgualRodada) w_proximo = E_PROXIMA;
                else if (fimRodadas)           w_proximo = E_FIM_GANHOU;
                else                           w_proximo = E_ESPERA_NOVA;
            end
            E_PROXIMA: begin
                contaE    = 1'b1;
                w_proximo = E_ESPERA;
            end
            E_ESPERA_NOVA: begin
                if (jogada_feita)       w_proximo = E_REGISTRA_NOVA;
                else if (w_fim_timeout) w_proximo = E_FIM_TIMEOUT;
            end
            E_REGISTRA_NOVA: begin
                registraR = 1'b1;
                contaE    = 1'b1;
                w_proximo = E_ESCREVE;
            end
            E_ESCREVE: begin
                escreveM  = 1'b1;
                w_proximo = E_PROXIMA_RODADA;
            end
            E_PROXIMA_RODADA: begin
                contaR    = 1'b1;
                zeraE     = 1'b1;
                w_proximo = E_ESPERA;
            end
            E_FIM_GANHOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (iniciar) w_proximo = E_PREPARA;
            end
            E_FIM_PERDEU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (iniciar) w_proximo = E_PREPARA;
            end
            E_FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
                if (iniciar) w_proximo = E_PREPARA;
            end
            default: w_proximo = E_INICIAL;
        endcase
    end

    assign db_estado = r_estado;

endmodule

// File: tb/tb_controle_jogo_sequencia.sv
// Directed bench for controle_jogo_sequencia with a small round/address
// counter model standing in for the datapath.
module tb_controle_jogo_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual = 1'b1;
    logic       enderecoIgualRodada;
    logic       fimRodadas;
    logic       zeraE, contaE, zeraR, contaR, registraR, escreveM;
    logic       ativa_leds, pronto, ganhou, perdeu, db_timeout;
    logic [4:0] db_estado;

    int errors = 0;
    int checks = 0;

    logic [4:0] m_addr  = 5'd0;
    logic [4:0] m_round = 5'd0;
    int         n_escreve = 0;
    int         n_contaR  = 0;
    int         n_viol    = 0;
    logic [5:0] prev_en   = 6'd0;
    logic [5:0] w_en;
    logic [10:0] w_saidas;

    assign w_en     = {zeraE, contaE, zeraR, contaR, registraR, escreveM};
    assign w_saidas = {w_en, ativa_leds, pronto, ganhou, perdeu, db_timeout};

    always #5 clock = ~clock;

    controle_jogo_sequencia dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .jogada_feita        (jogada_feita),
        .igual               (igual),
        .enderecoIgualRodada (enderecoIgualRodada),
        .fimRodadas          (fimRodadas),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .zeraR               (zeraR),
        .contaR              (contaR),
        .registraR           (registraR),
        .escreveM            (escreveM),
        .ativa_leds          (ativa_leds),
        .pronto              (pronto),
        .ganhou              (ganhou),
        .perdeu              (perdeu),
        .db_timeout          (db_timeout),
        .db_estado           (db_estado)
    );

    // Datapath stand-in: address and round counters follow the DUT enables.
    assign enderecoIgualRodada = (m_addr == m_round);
    assign fimRodadas          = (m_round == 5'd15);

    always @(posedge clock) begin
        if (zeraE)       m_addr <= 5'd0;
        else if (contaE) m_addr <= m_addr + 5'd1;
        if (zeraR)       m_round <= 5'd0;
        else if (contaR) m_round <= m_round + 5'd1;
    end

    always @(negedge clock) begin
        n_viol  = n_viol + $countones(w_en & prev_en);
        prev_en = w_en;
        if (escreveM) n_escreve = n_escreve + 1;
        if (contaR)   n_contaR  = n_contaR + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, state=%h", db_estado);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic go_to_espera();
        int k;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 5'h01) begin
            errors++;
            $display("FAIL start_prepara: state=%h expected=01", db_estado);
        end
        for (k = 0; k < 1100 && db_estado !== 5'h04; k++) tick();
        checks++;
        if (db_estado !== 5'h04) begin
            errors++;
            $display("FAIL reach_espera: state=%h expected=04 after %0d cycles", db_estado, k);
        end
    endtask

    // Plays every stored address of round r correctly, then appends the new play.
    task automatic play_round(input int r);
        logic [4:0] exp_st;
        for (int a = 0; a <= r; a++) begin
            jogada_feita = 1'b1;
            igual = 1'b1;
            tick();
            jogada_feita = 1'b0;
            checks++;
            if (db_estado !== 5'h05 || registraR !== 1'b1) begin
                errors++;
                $display("FAIL round%0d_registra: state=%h registraR=%b expected=05/1", r, db_estado, registraR);
            end
            tick();
            checks++;
            if (db_estado !== 5'h06) begin
                errors++;
                $display("FAIL round%0d_compara: state=%h expected=06", r, db_estado);
            end
            tick();
            exp_st = (a < r) ? 5'h07 : ((r == 15) ? 5'h0C : 5'h08);
            checks++;
            if (db_estado !== exp_st) begin
                errors++;
                $display("FAIL round%0d_addr%0d_next: state=%h expected=%h", r, a, db_estado, exp_st);
            end
            if (a < r) tick();
        end
        if (r < 15) begin
            jogada_feita = 1'b1;
            tick();
            jogada_feita = 1'b0;
            checks++;
            if (db_estado !== 5'h09 || w_en !== 6'b010010) begin
                errors++;
                $display("FAIL round%0d_registra_nova: state=%h en=%b expected=09/010010", r, db_estado, w_en);
            end
            tick();
            checks++;
            if (db_estado !== 5'h0A || w_en !== 6'b000001) begin
                errors++;
                $display("FAIL round%0d_escreve: state=%h en=%b expected=0a/000001", r, db_estado, w_en);
            end
            tick();
            checks++;
            if (db_estado !== 5'h0B || w_en !== 6'b100100) begin
                errors++;
                $display("FAIL round%0d_proxima_rodada: state=%h en=%b expected=0b/100100", r, db_estado, w_en);
            end
            tick();
            checks++;
            if (db_estado !== 5'h04 || w_saidas !== 11'd0) begin
                errors++;
                $display("FAIL round%0d_back_espera: state=%h outs=%b expected=04/0", r, db_estado, w_saidas);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (db_estado !== 5'h00 || w_saidas !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: state=%h outs=%b expected=00/0", db_estado, w_saidas);
        end
        reset = 1'b1;
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (11) tick();
        checks++;
        if (db_estado !== 5'h02 || ativa_leds !== 1'b1) begin
            errors++;
            $display("FAIL mid_mostra: state=%h leds=%b expected=02/1", db_estado, ativa_leds);
        end
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 5'h00 || w_saidas !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: state=%h outs=%b expected=00/0", db_estado, w_saidas);
        end
        tick();
        reset = 1'b1;
        tick();
        n = 0;
        iniciar = 1'b1;
        tick();
        checks++;
        if (db_estado !== 5'h01 || w_saidas !== 11'b10100000000) begin
            errors++;
            $display("FAIL prepara: state=%h outs=%b expected=01/10100000000", db_estado, w_saidas);
        end
        for (int k = 0; k < 1100; k++) begin
            tick();
            if (k == 3) iniciar = 1'b0;
            if (db_estado === 5'h02 && ativa_leds === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != 1000) begin
            errors++;
            $display("FAIL mostra_length: leds_cycles=%0d expected=1000", n);
        end
        checks++;
        if (db_estado !== 5'h03 || w_saidas !== 11'b10000000000) begin
            errors++;
            $display("FAIL apaga: state=%h outs=%b expected=03/10000000000", db_estado, w_saidas);
        end
        tick();
        checks++;
        if (db_estado !== 5'h04 || w_saidas !== 11'd0) begin
            errors++;
            $display("FAIL espera: state=%h outs=%b expected=04/0", db_estado, w_saidas);
        end
    endtask

    task automatic test_timeout();
        repeat (2999) tick();
        checks++;
        if (db_estado !== 5'h04) begin
            errors++;
            $display("FAIL timeout_early: state=%h expected=04", db_estado);
        end
        tick();
        checks++;
        if (db_estado !== 5'h0E || {pronto, ganhou, perdeu, db_timeout} !== 4'b1011) begin
            errors++;
            $display("FAIL timeout_end: state=%h pgpt=%b expected=0e/1011",
                     db_estado, {pronto, ganhou, perdeu, db_timeout});
        end
        go_to_espera();
        repeat (2999) tick();
        jogada_feita = 1'b1;
        igual = 1'b1;
        tick();
        jogada_feita = 1'b0;
        checks++;
        if (db_estado !== 5'h05 || registraR !== 1'b1) begin
            errors++;
            $display("FAIL timeout_coincident: state=%h registraR=%b expected=05/1", db_estado, registraR);
        end
        tick();
        tick();
        checks++;
        if (db_estado !== 5'h08) begin
            errors++;
            $display("FAIL coincident_compara: state=%h expected=08", db_estado);
        end
        jogada_feita = 1'b1;
        tick();
        jogada_feita = 1'b0;
        repeat (3) tick();
        checks++;
        if (db_estado !== 5'h04) begin
            errors++;
            $display("FAIL coincident_round_done: state=%h expected=04", db_estado);
        end
    endtask

    task automatic test_iniciar_ignored();
        int bad;
        bad = 0;
        iniciar = 1'b1;
        repeat (5) begin
            tick();
            if (db_estado !== 5'h04) bad++;
        end
        iniciar = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL iniciar_ignored: cycles_off_espera=%0d expected=0", bad);
        end
        jogada_feita = 1'b1;
        igual = 1'b0;
        tick();
        jogada_feita = 1'b0;
        tick();
        tick();
        igual = 1'b1;
        checks++;
        if (db_estado !== 5'h0D) begin
            errors++;
            $display("FAIL ignored_then_wrong: state=%h expected=0d", db_estado);
        end
    endtask

    task automatic test_wrong_play();
        int bad;
        go_to_espera();
        play_round(0);
        play_round(1);
        jogada_feita = 1'b1;
        igual = 1'b0;
        tick();
        jogada_feita = 1'b0;
        tick();
        checks++;
        if (db_estado !== 5'h06) begin
            errors++;
            $display("FAIL wrong_compara: state=%h expected=06", db_estado);
        end
        tick();
        igual = 1'b1;
        checks++;
        if (db_estado !== 5'h0D || {pronto, ganhou, perdeu, db_timeout} !== 4'b1010) begin
            errors++;
            $display("FAIL wrong_result: state=%h pgpt=%b expected=0d/1010",
                     db_estado, {pronto, ganhou, perdeu, db_timeout});
        end
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            jogada_feita = (k % 7 == 3);
            tick();
            if (db_estado !== 5'h0D || pronto !== 1'b1) bad++;
        end
        jogada_feita = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL perdeu_hold: cycles_off=%0d expected=0", bad);
        end
    endtask

    task automatic test_win();
        go_to_espera();
        n_escreve = 0;
        n_contaR  = 0;
        for (int r = 0; r <= 15; r++) play_round(r);
        checks++;
        if (db_estado !== 5'h0C || {pronto, ganhou, perdeu} !== 3'b110) begin
            errors++;
            $display("FAIL win_result: state=%h pgp=%b expected=0c/110", db_estado, {pronto, ganhou, perdeu});
        end
        checks++;
        if (n_escreve != 15) begin
            errors++;
            $display("FAIL win_writes: escreveM=%0d expected=15", n_escreve);
        end
        checks++;
        if (n_contaR != 15) begin
            errors++;
            $display("FAIL win_contaR: contaR=%0d expected=15", n_contaR);
        end
    endtask

    task automatic test_restart_from_win();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 5'h01 || w_saidas !== 11'b10100000000) begin
            errors++;
            $display("FAIL restart_prepara: state=%h outs=%b expected=01/10100000000", db_estado, w_saidas);
        end
        tick();
        checks++;
        if (db_estado !== 5'h02 || w_saidas !== 11'b00000010000) begin
            errors++;
            $display("FAIL restart_mostra: state=%h outs=%b expected=02/00000010000", db_estado, w_saidas);
        end
    endtask

    task automatic test_single_pulses();
        checks++;
        if (n_viol != 0) begin
            errors++;
            $display("FAIL enable_pulses: consecutive_enable_cycles=%0d expected=0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_iniciar_ignored();
        test_wrong_play();
        test_win();
        test_restart_from_win();
        test_single_pulses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
